// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit controller:
//   DATA_WIDTH         payload bits per frame
//   PAR_EVEN/PAR_ODD   encodings of the PAR_TYP input
//   txState_t          transmit FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_t;

endpackage

// File: rtl/uart_parity_calc.sv
// ---------------------------------------------------------------------------
// uart_parity_calc
// Parity generator for one UART payload.
// Ports:
//   data_i    payload word
//   type_i    parity type (PAR_EVEN / PAR_ODD)
//   parity_o  parity bit to place after the data bits
// ---------------------------------------------------------------------------
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             type_i,
    output logic             parity_o
);

    // Even parity makes the total count of ones even, so it is the XOR of
    // the payload; odd parity is its complement.
    assign parity_o = (^data_i) ^ (type_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_controller.sv
// ---------------------------------------------------------------------------
// uart_tx_controller
// Frame sequencer for a UART transmitter that works with an external
// Serializer. Frame: START(0), 8 data bits LSB first, optional PARITY, STOP(1).
// Ports:
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   P_DATA      parallel payload, sampled when a request is accepted
//   Data_Valid  request to send P_DATA
//   PAR_EN      parity enable, sampled on accept
//   PAR_TYP     parity type (0 even, 1 odd), sampled on accept
//   Ser_Data    serial bit coming back from the Serializer
//   Ser_En      one-cycle load pulse to the Serializer
//   Send_Data   shift command to the Serializer
//   TX_OUT      UART line, idle high
//   Busy        frame in progress
// ---------------------------------------------------------------------------
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  Ser_Data,
    output logic                  Ser_En,
    output logic                  Send_Data,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam logic [2:0] CNT_LAST = 3'(DATA_WIDTH - 1);

    txState_t              state_q,   state_d;
    logic [2:0]            bitCnt_q,  bitCnt_d;
    logic [DATA_WIDTH-1:0] dataReg_q, dataReg_d;
    logic                  parEn_q,   parEn_d;
    logic                  parTyp_q,  parTyp_d;
    logic                  parBit_q,  parBit_d;
    logic                  accept;
    logic                  parCalc;

    // A new request is only taken between frames or in the STOP cycle, so
    // frames can run back to back. Reset wins over a simultaneous request.
    assign accept = Data_Valid && !RST && ((state_q == IDLE) || (state_q == STOP));

    // Frame parameters are captured on accept and held for the whole frame;
    // the parity bit is formed from the word being captured.
    always_comb begin
        dataReg_d = accept ? P_DATA  : dataReg_q;
        parEn_d   = accept ? PAR_EN  : parEn_q;
        parTyp_d  = accept ? PAR_TYP : parTyp_q;
        parBit_d  = accept ? parCalc : parBit_q;
    end

    uart_parity_calc #(
        .WIDTH    (DATA_WIDTH)
    ) uParity (
        .data_i   (dataReg_d),
        .type_i   (parTyp_d),
        .parity_o (parCalc)
    );

    // State, bit counter and captured frame parameters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            dataReg_q <= '0;
            parEn_q   <= 1'b0;
            parTyp_q  <= 1'b0;
            parBit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            dataReg_q <= dataReg_d;
            parEn_q   <= parEn_d;
            parTyp_q  <= parTyp_d;
            parBit_q  <= parBit_d;
        end
    end

    // Next state and outputs. Send_Data is high in START and the first seven
    // DATA cycles: the Serializer presents bit 0 after the START shift, so
    // eight shifts in total walk it through all payload bits.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        Ser_En    = 1'b0;
        Send_Data = 1'b0;
        TX_OUT    = 1'b1;
        Busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    Ser_En  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                TX_OUT    = 1'b0;
                Busy      = 1'b1;
                Send_Data = 1'b1;
                state_d   = DATA;
            end
            DATA: begin
                TX_OUT    = Ser_Data;
                Busy      = 1'b1;
                Send_Data = (bitCnt_q != CNT_LAST);
                // The counter simply rolls from 7 back to 0 on the way out.
                bitCnt_d  = bitCnt_q + 3'd1;
                if (bitCnt_q == CNT_LAST) begin
                    state_d = parEn_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                TX_OUT  = parBit_q;
                Busy    = 1'b1;
                state_d = STOP;
            end
            STOP: begin
                Busy = 1'b1;
                if (accept) begin
                    Ser_En  = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_controller.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_controller
// Bench for uart_tx_controller paired with a behavioural Serializer. Every
// cycle the line, Busy, Send_Data and Ser_En are compared with records
// queued when a request is issued; whole-frame line patterns and Busy
// lengths are also compared against literal values.
// ---------------------------------------------------------------------------
module tb_uart_tx_controller;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       Ser_Data;
    logic       Ser_En;
    logic       Send_Data;
    logic       TX_OUT;
    logic       Busy;

    typedef struct packed {
        logic tx;
        logic busy;
        logic send;
    } outRec_t;

    outRec_t     expQ[$];
    int          checks;
    int          failures;
    int          cycleNo;
    int          busyCount;
    logic [15:0] txLog;

    // Serializer model: load on enable, otherwise shift the LSB out to a
    // registered output on each shift command. Its reset is active-low.
    logic [7:0] serReg;
    logic       outS;
    logic       serRstN;

    assign serRstN  = ~RST;
    assign Ser_Data = outS;

    always @(posedge CLK) begin
        if (!serRstN) begin
            serReg <= 8'h00;
            outS   <= 1'b0;
        end else if (Ser_En) begin
            serReg <= P_DATA;
        end else if (Send_Data) begin
            outS   <= serReg[0];
            serReg <= {1'b0, serReg[7:1]};
        end
    end

    uart_tx_controller #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Ser_Data   (Ser_Data),
        .Ser_En     (Ser_En),
        .Send_Data  (Send_Data),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    // Free-running clock, 10 time units per period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h",
                   tag, cycleNo, observed, expected);
        end
    endtask

    // Queue the per-cycle line/Busy/Send_Data records of one frame.
    task automatic pushFrame(input logic [7:0] data, input logic pen, input logic ptyp);
        int ones;
        ones = 0;
        expQ.push_back('{tx: 1'b0, busy: 1'b1, send: 1'b1});
        for (int i = 0; i < 8; i++) begin
            expQ.push_back('{tx: data[i], busy: 1'b1, send: (i < 7)});
            if (data[i]) ones++;
        end
        if (pen) begin
            expQ.push_back('{tx: ((ones % 2) == 1) ^ ptyp, busy: 1'b1, send: 1'b0});
        end
        expQ.push_back('{tx: 1'b1, busy: 1'b1, send: 1'b0});
    endtask

    // Drive one cycle of inputs after the falling edge, then compare the
    // outputs of that cycle before the next rising edge.
    task automatic applyStimulus(input logic rst, input logic dv, input logic [7:0] data,
                                 input logic pen, input logic ptyp, input logic expAccept);
        outRec_t exp;
        @(negedge CLK);
        RST        = rst;
        Data_Valid = dv;
        P_DATA     = data;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        #1;
        cycleNo++;
        if (expQ.size() > 0) exp = expQ.pop_front();
        else exp = '{tx: 1'b1, busy: 1'b0, send: 1'b0};
        checkOutput("tx_out",    {15'd0, TX_OUT},    {15'd0, exp.tx});
        checkOutput("busy",      {15'd0, Busy},      {15'd0, exp.busy});
        checkOutput("send_data", {15'd0, Send_Data}, {15'd0, exp.send});
        checkOutput("ser_en",    {15'd0, Ser_En},    {15'd0, expAccept});
        txLog = {txLog[14:0], TX_OUT};
        if (Busy === 1'b1) busyCount++;
        if (rst) expQ.delete();
        if (expAccept) pushFrame(data, pen, ptyp);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Directed sequence of scenarios.
    initial begin
        checks     = 0;
        failures   = 0;
        cycleNo    = 0;
        busyCount  = 0;
        txLog      = '0;
        RST        = 1'b1;
        Data_Valid = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset state, including reset beating a simultaneous request.
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        idleCycles(1);

        // A5 without parity: 10-cycle frame, then idle.
        busyCount = 0;
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        idleCycles(10);
        checkOutput("frame_a5_noparity", txLog & 16'h03FF, 16'b0101001011);
        idleCycles(1);
        checkOutput("busy_len_noparity", 16'(busyCount), 16'd10);

        // A5 with even parity, then odd parity: 11-cycle frames.
        busyCount = 0;
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        idleCycles(11);
        checkOutput("frame_a5_even", txLog & 16'h07FF, 16'b01010010101);
        checkOutput("busy_len_parity", 16'(busyCount), 16'd11);
        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        idleCycles(11);
        checkOutput("frame_a5_odd", txLog & 16'h07FF, 16'b01010010111);
        idleCycles(1);

        // 01 with even parity: single one in bit 0, parity bit 1.
        applyStimulus(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        idleCycles(11);
        checkOutput("frame_01_even", txLog & 16'h07FF, 16'b01000000011);
        idleCycles(1);

        // Data_Valid held high: second frame starts right after first STOP.
        busyCount = 0;
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        idleCycles(10);
        checkOutput("busy_len_back2back", 16'(busyCount), 16'd20);
        checkOutput("frame_c3", txLog & 16'h03FF, 16'b0110000111);
        idleCycles(2);

        // Reset in DATA bit 4 aborts the frame; a following FF frame is clean.
        applyStimulus(1'b0, 1'b1, 8'h96, 1'b0, 1'b0, 1'b1);
        idleCycles(5);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        idleCycles(11);
        checkOutput("frame_ff_even", txLog & 16'h07FF, 16'b01111111101);
        idleCycles(1);

        // Request during DATA is ignored; no extra frame follows.
        busyCount = 0;
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        idleCycles(6);
        checkOutput("frame_55", txLog & 16'h03FF, 16'b0101010101);
        idleCycles(4);
        checkOutput("busy_len_ignored_req", 16'(busyCount), 16'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_controller.md
UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame (the only supported value is 8).
REQ-002 SHALL have CLK  input  1  single clock for all logic, rising edge.
REQ-003 SHALL have RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have P_DATA  input  8  parallel payload, sampled on the accept cycle.
REQ-005 SHALL have Data_Valid  input  1  request to send P_DATA.
REQ-006 SHALL have PAR_EN  input  1  parity bit enable, sampled on the accept cycle.
REQ-007 SHALL have PAR_TYP  input  1  parity type (0 = even, 1 = odd), sampled on the accept cycle.
REQ-008 SHALL have Ser_Data  input  1  serial bit returned by the Serializer (its OUT_S).
REQ-009 SHALL have Ser_En  output  1  one-cycle pulse that loads P_DATA into the Serializer.
REQ-010 SHALL have Send_Data  output  1  shift command to the Serializer.
REQ-011 SHALL have TX_OUT  output  1  UART line, idle high.
REQ-012 SHALL have Busy  output  1  frame in progress.

Function
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP, with a 3-bit bit counter.
REQ-014 SHALL accept Data_Valid only in IDLE or STOP; on accept:
- latch P_DATA, PAR_EN and PAR_TYP;
- pulse Ser_En for that cycle;
- go to START next cycle.
REQ-015 SHALL ignore Data_Valid in START, DATA and PARITY (no queuing, no error flag).
REQ-016 SHALL drive TX_OUT combinationally from the registered state:
- IDLE = 1;
- START = 0;
- DATA = Ser_Data;
- PARITY = latched parity bit;
- STOP = 1.
REQ-017 SHALL assert Send_Data in START and in DATA bit-counts 0..6 (exactly 8 cycles), and deassert it in DATA bit-count 7 and all other states.
REQ-018 SHALL hold START for 1 cycle, then go to DATA with the counter at 0; DATA lasts 8 cycles, with the counter incrementing each cycle.
REQ-019 SHALL leave DATA at counter 7: to PARITY if latched PAR_EN = 1, otherwise to STOP.
REQ-020 SHALL hold PARITY for 1 cycle, then go to STOP.
REQ-021 SHALL hold STOP for 1 cycle, then go to START if a new request is accepted in that cycle, otherwise to IDLE.
REQ-022 SHALL compute the parity bit at accept time:
- even parity = XOR of the latched 8 bits;
- odd parity = its inverse.
REQ-023 SHALL give a frame length of 10 cycles (START to STOP inclusive) with PAR_EN = 0, and 11 cycles with PAR_EN = 1.
REQ-024 SHALL send back-to-back frames with no idle cycle between STOP and the next START when Data_Valid is held high.
REQ-025 SHALL drive Busy = 1 in START, DATA, PARITY and STOP, and Busy = 0 in IDLE.
REQ-026 SHALL wrap the bit counter from 7 to 0 on leaving DATA, with no other wrap path.

Reset
REQ-027 SHALL, while RST = 1 at a rising edge, set the state to IDLE, the counter to 0, and the latched data and parity registers to 0.
REQ-028 SHALL produce these outputs in the cycle after reset: TX_OUT = 1, Busy = 0, Ser_En = 0, Send_Data = 0.
REQ-029 SHALL abort a frame on reset mid-frame, with no partial STOP emitted.
REQ-030 SHALL give RST priority over Data_Valid in the same cycle.

Structure
REQ-031 SHALL place the state encoding, DATA_WIDTH and the PAR_EVEN/PAR_ODD constants in the shared package uart_pkg.
REQ-032 SHALL place the parity reduction in one sub-module, uart_parity_calc (inputs: data, type; output: parity bit).
REQ-033 SHALL keep the FSM, bit counter and output mux in uart_tx_controller, with no other sub-modules.

Verification
REQ-034 SHALL run the bench with uart_tx_controller connected to the Serializer:
- Serializer_Enable_S = Ser_En;
- Send_Data_S = Send_Data;
- Ser_Data = OUT_S;
- Serializer RST = ~RST.
REQ-035 Scenario 1: P_DATA = 8'hA5, PAR_EN = 0, one-cycle Data_Valid -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles, then idle 1; Busy high for exactly 10 cycles.
REQ-036 Scenario 2: P_DATA = 8'hA5, PAR_EN = 1, PAR_TYP = 0 -> parity bit 0 in cycle 10, STOP in cycle 11; with PAR_TYP = 1 -> parity bit 1.
REQ-037 Scenario 3: P_DATA = 8'h01, PAR_EN = 1, PAR_TYP = 0 -> data bits 1,0,0,0,0,0,0,0 and parity bit 1.
REQ-038 Scenario 4: Data_Valid held high with P_DATA = 8'h3C then 8'hC3 -> second START immediately follows first STOP; Ser_En pulses in the IDLE and STOP cycles only.
REQ-039 Scenario 5: RST = 1 in DATA bit 4 -> next cycle IDLE, TX_OUT = 1, Busy = 0, Send_Data = 0; a subsequent 8'hFF frame is correct.
REQ-040 Scenario 6: Data_Valid pulsed during DATA of an 8'h55 frame -> ignored; the line returns to idle after STOP with no extra frame.
